// File: rtl/masked_accum_ctrl.sv
// masked_accum_ctrl: sequences masked beats into an external NUM-lane adder and accumulates its sums into one result.
// Ports: clk, rst (sync, active high); start/beats job request; busy;
//        in_valid/in_ready/in_mask/in_data beat input; adder_ctr/adder_data/adder_sum adder link;
//        out_valid/out_ready/out_sum result output; beats_left remaining beat count.
// Optional: define MASKED_ACCUM_SAT_EN to saturate the accumulation instead of wrapping.
module masked_accum_ctrl #(
    parameter int NUM      = 4,
    parameter int bitwidth = 16,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        beats,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM-1:0]          in_mask,
    input  logic [NUM*bitwidth-1:0] in_data,
    output logic [NUM-1:0]          adder_ctr,
    output logic [NUM*bitwidth-1:0] adder_data,
    input  logic [bitwidth-1:0]     adder_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [bitwidth-1:0]     out_sum,
    output logic [CNT_W-1:0]        beats_left
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]          state;
    logic [bitwidth-1:0] acc;
    logic [bitwidth-1:0] acc_next;
    logic                take;
    assign in_ready   = state == ACCUM;
    assign busy       = state != IDLE;
    assign take       = in_valid & in_ready;
    // lanes are only enabled on the cycle a beat is actually consumed
    assign adder_ctr  = in_mask & {NUM{take}};
    assign adder_data = in_data;
`ifdef MASKED_ACCUM_SAT_EN
    logic [bitwidth:0] wide;
    assign wide     = {1'b0, acc} + {1'b0, adder_sum};
    assign acc_next = wide[bitwidth] ? '1 : wide[bitwidth-1:0];
`else
    assign acc_next = acc + adder_sum;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            out_sum    <= '0;
            out_valid  <= 1'b0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (beats != '0) begin
                        acc        <= '0;
                        beats_left <= beats;
                        state      <= ACCUM;
                    end else begin
                        out_sum    <= '0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                ACCUM: if (take) begin
                    acc        <= acc_next;
                    beats_left <= beats_left - 1'b1;
                    if (beats_left == CNT_W'(1)) begin
                        out_sum   <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_masked_accum_ctrl.sv
// tb_masked_accum_ctrl: directed scoreboard bench for masked_accum_ctrl.
module tb_masked_accum_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [7:0]  beats, beats_left;
    logic        busy, in_ready, out_valid;
    logic [3:0]  in_mask, adder_ctr;
    logic [63:0] in_data, adder_data;
    logic [15:0] adder_sum, out_sum;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    masked_accum_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .beats(beats), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_data(in_data),
        .adder_ctr(adder_ctr), .adder_data(adder_data), .adder_sum(adder_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .beats_left(beats_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] sum, input logic [3:0] mask);
        in_valid  = 1'b1;
        in_mask   = mask;
        adder_sum = sum;
        #1;
        chk("adder_ctr_on_accept", 32'(adder_ctr), 32'(mask));
        tick();
        in_valid  = 1'b0;
        in_mask   = 4'b0;
        adder_sum = 16'h0;
    endtask

    task automatic job(input logic [7:0] n);
        start = 1'b1;
        beats = n;
        tick();
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected: got %0h expected none", out_sum);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (out_sum !== e) begin
                    n_err++;
                    $display("FAIL result: got %0h expected %0h", out_sum, e);
                end
            end
        end
    end

    initial begin
        logic [15:0] ovf_exp;
        rst = 1'b1; start = 1'b0; beats = 8'd0; in_valid = 1'b0; out_ready = 1'b1;
        in_mask = 4'b0; in_data = 64'h0; adder_sum = 16'h0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_beats_left", 32'(beats_left), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        rst = 1'b0;
        tick();
        // single beat
        in_data = {16'd9, 16'd100, 16'd7, 16'd5};
        job(8'd1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_in_ready", 32'(in_ready), 1);
        chk("t1_beats_left", 32'(beats_left), 1);
        chk("t1_ctr_idle", 32'(adder_ctr), 0);
        chk("t1_data_pass", 32'(adder_data[47:32]), 100);
        exp_q.push_back(16'd21);
        beat(16'd21, 4'b1011);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_sum", 32'(out_sum), 21);
        chk("t1_ctr_after", 32'(adder_ctr), 0);
        tick();
        chk("t1_drained", 32'(out_valid), 0);
        // three beats with gaps
        job(8'd3);
        chk("t2_bl3", 32'(beats_left), 3);
        tick();
        chk("t2_bl3_gap", 32'(beats_left), 3);
        chk("t2_ready_gap", 32'(in_ready), 1);
        beat(16'd10, 4'b0001);
        chk("t2_bl2", 32'(beats_left), 2);
        tick();
        chk("t2_ready_gap2", 32'(in_ready), 1);
        beat(16'd0, 4'b0000);
        chk("t2_bl1", 32'(beats_left), 1);
        chk("t2_ready", 32'(in_ready), 1);
        exp_q.push_back(16'd42);
        beat(16'd32, 4'b1111);
        chk("t2_bl0", 32'(beats_left), 0);
        chk("t2_out_sum", 32'(out_sum), 42);
        tick();
        // zero-length job
        exp_q.push_back(16'd0);
        in_valid = 1'b1;
        job(8'd0);
        chk("t3_out_valid", 32'(out_valid), 1);
        chk("t3_out_sum", 32'(out_sum), 0);
        chk("t3_bl", 32'(beats_left), 0);
        chk("t3_in_ready", 32'(in_ready), 0);
        chk("t3_ctr", 32'(adder_ctr), 0);
        in_valid = 1'b0;
        tick();
        chk("t3_idle", 32'(busy), 0);
        // backpressure
        out_ready = 1'b0;
        job(8'd1);
        exp_q.push_back(16'd7);
        beat(16'd7, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            chk("t4_out_sum_hold", 32'(out_sum), 7);
            chk("t4_valid_hold", 32'(out_valid), 1);
            chk("t4_in_ready", 32'(in_ready), 0);
            start = (i == 2);
            beats = 8'd2;
            tick();
        end
        start = 1'b0;
        chk("t4_bl_ignored", 32'(beats_left), 0);
        out_ready = 1'b1;
        tick();
        chk("t4_idle", 32'(busy), 0);
        job(8'd1);
        chk("t4_new_job", 32'(beats_left), 1);
        exp_q.push_back(16'd5);
        beat(16'd5, 4'b0010);
        tick();
        // overflow
`ifdef MASKED_ACCUM_SAT_EN
        ovf_exp = 16'hFFFF;
`else
        ovf_exp = 16'h0010;
`endif
        job(8'd2);
        exp_q.push_back(ovf_exp);
        beat(16'hFFF0, 4'b1111);
        beat(16'h0020, 4'b1111);
        chk("t5_out_sum", 32'(out_sum), 32'(ovf_exp));
        tick();
        // reset mid-job
        job(8'd4);
        beat(16'd1, 4'b0001);
        beat(16'd2, 4'b0001);
        chk("t6_bl2", 32'(beats_left), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_bl", 32'(beats_left), 0);
        chk("t6_in_ready", 32'(in_ready), 0);
        job(8'd1);
        exp_q.push_back(16'd3);
        beat(16'd3, 4'b0100);
        chk("t6_out_sum", 32'(out_sum), 3);
        tick();
        tick();
        chk("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/masked_accum_ctrl.md
Name: masked_accum_ctrl

Overview:
Sequencer for the NUM-lane masked adder chain used in feature aggregation.
- Accepts a job of `beats` masked input vectors and presents each beat to the external adder (lane enable mask plus packed data).
- Accumulates the adder's per-beat sum across the job and returns one aggregated result over a valid/ready output handshake.
- Sits between the neighbour-feature fetch stream and the aggregation writeback.

Parameters:
- NUM, 4, lane count; width of the lane mask and of the adder enable vector.
- bitwidth, 16, width of one lane, of the adder sum and of the accumulator.
- CNT_W, 8, width of the beat count; maximum job length is 2^CNT_W-1 beats.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- beats  in  CNT_W  number of beats in the job; sampled with start.
- busy  out  1  high in ACCUM and DONE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  beat accept; high only in ACCUM.
- in_mask  in  NUM  per-lane enable for the beat.
- in_data  in  NUM*bitwidth  packed lane data; lane i occupies bits [i*bitwidth +: bitwidth].
- adder_ctr  out  NUM  lane enables driven to the adder.
- adder_data  out  NUM*bitwidth  packed data driven to the adder.
- adder_sum  in  bitwidth  combinational sum returned by the adder.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_sum  out  bitwidth  aggregated result.
- beats_left  out  CNT_W  beats remaining in the current job.

Behaviour:
- Reset: state=IDLE; acc=0, out_sum=0, beats_left=0; out_valid=0, in_ready=0, busy=0.
- Reset asserted mid-job abandons the job: no result is produced and any partial acc is discarded.
- A beat is accepted when in_valid & in_ready.
- Adder drive is combinational:
  - adder_ctr = in_mask & {NUM{in_valid & in_ready}}.
  - adder_data = in_data.
  - So adder_ctr is all zeros whenever no beat is accepted.
- State IDLE:
  - in_ready=0.
  - start & beats!=0: acc<=0, beats_left<=beats, go to ACCUM.
  - start & beats==0: out_sum<=0, out_valid<=1, go to DONE.
  - start low: stay in IDLE.
- State ACCUM:
  - in_ready=1.
  - On an accepted beat: acc <= acc + adder_sum, beats_left <= beats_left-1.
  - If the accepted beat is the last one (beats_left==1): out_sum <= acc + adder_sum, out_valid <= 1, beats_left <= 0, go to DONE.
  - Latency: out_valid rises on the cycle after the last beat is accepted.
  - in_valid low: all state holds.
- State DONE:
  - in_ready=0; out_sum and out_valid hold stable while out_ready is low.
  - out_valid & out_ready: out_valid<=0, go to IDLE.
  - The next start is honoured no earlier than the cycle after the return to IDLE.
  - A start seen while the result drains in DONE is ignored, as is any start outside IDLE.
- Arithmetic:
  - Unsigned, bitwidth bits.
  - Without the optional feature, the accumulation wraps modulo 2^bitwidth.
  - adder_sum is taken as-is; any wrap inside the adder is out of scope for this block.
- A beat with mask all zeros is legal: it counts as a beat and adds 0.
- in_valid outside ACCUM is ignored and no beat is consumed.

Optional Feature:
- Macro: MASKED_ACCUM_SAT_EN.
- When defined:
  - Accumulation saturates: if acc + adder_sum exceeds 2^bitwidth-1, acc and out_sum clamp to all ones.
  - Once clamped, the value stays clamped for the rest of the job.
- When undefined: wrap-around as stated under Arithmetic.

Test Plan:
- Single beat: start, beats=1; beat mask=4'b1011, lanes {0:5, 1:7, 2:100, 3:9}; adder returns 21 -> out_sum=21, out_valid high on the cycle after acceptance; adder_ctr=4'b1011 only during the accept cycle.
- Three beats with in_valid gaps; adder returns 10, 0 (mask 0000), 32 -> out_sum=42, beats_left counts 3,2,1,0, in_ready held high throughout ACCUM.
- Zero-length job: start, beats=0 -> DONE on the next cycle with out_sum=0, out_valid=1, and no beat consumed.
- Backpressure: out_ready held low for 5 cycles -> out_sum stable, in_ready=0; a start pulse during this window is ignored; out_ready=1 -> IDLE, and a new job then starts.
- Overflow with bitwidth=16, adder returns 0xFFF0 then 0x0020 -> out_sum=0x0010 without the macro, 0xFFFF with MASKED_ACCUM_SAT_EN.
- Reset mid-job: rst after 2 of 4 beats -> IDLE, out_valid=0, beats_left=0; a subsequent job of beats=1 with adder returning 3 yields out_sum=3, showing no residual acc.
